// File: rtl/servo_pkg.sv
// Shared servo command definitions: position codes, generator FSM states and
// the microsecond-to-cycle helper, common to the decoder and the PWM generator.
package servo_pkg;
  localparam logic [1:0] POS_0   = 2'd0;
  localparam logic [1:0] POS_P90 = 2'd1;
  localparam logic [1:0] POS_N90 = 2'd2;
  localparam logic [1:0] POS_ERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } servo_state_e;

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned cyc_per_us);
    return us * cyc_per_us;
  endfunction
endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command/telemetry bundle between the servo command logic (master) and the
// PWM generator (slave).
interface servo_pwm_gen_if;
  logic       ENABLE;
  logic [1:0] grados;
  logic       pwm;
  logic       frame_tick;
  logic [1:0] pos_q;
  logic       settled;
  logic       err;

  modport master (output ENABLE, grados, input pwm, frame_tick, pos_q, settled, err);
  modport slave  (input ENABLE, grados, output pwm, frame_tick, pos_q, settled, err);
endinterface

// File: rtl/servo_settle_cnt.sv
// Saturating count of frames driven at an unchanged position; cleared at a
// frame start whose latched position differs, or that follows an idle period.
module servo_settle_cnt #(
  parameter int unsigned SETTLE_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_restart,
  input  logic [1:0] i_new_pos,
  input  logic [1:0] i_cur_pos,
  input  logic       i_tick,
  output logic       o_settled
);
  localparam int unsigned CW = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [CW-1:0] SAT = CW'(SETTLE_FRAMES);

  logic [CW-1:0] r_cnt;
  logic          w_clr;

  if (SETTLE_FRAMES < 1) begin : g_bad_settle
    $error("SETTLE_FRAMES must be at least 1");
  end

  assign w_clr = i_start && (i_restart || (i_new_pos != i_cur_pos));

  // The last tick of a frame coincides with the next start; a change wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_cnt <= '0;
    else if (w_clr)                  r_cnt <= '0;
    else if (i_tick && r_cnt != SAT) r_cnt <= r_cnt + CW'(1);
  end

  assign o_settled = (r_cnt == SAT);
endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: one pulse per frame, width chosen by the position
// latched at frame start, so pulses are never cut or stretched mid-frame.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 100000000,
  parameter int unsigned PERIOD_US     = 20000,
  parameter int unsigned PULSE_0_US    = 1500,
  parameter int unsigned PULSE_P90_US  = 2000,
  parameter int unsigned PULSE_N90_US  = 1000,
  parameter int unsigned SETTLE_FRAMES = 25
) (
  input logic            clk,
  input logic            reset,
  servo_pwm_gen_if.slave bus
);
  localparam int unsigned CYC_PER_US    = CLK_FREQ_HZ / 1000000;
  localparam int unsigned PERIOD_CYC    = us_to_cyc(PERIOD_US, CYC_PER_US);
  localparam int unsigned PULSE_0_CYC   = us_to_cyc(PULSE_0_US, CYC_PER_US);
  localparam int unsigned PULSE_P90_CYC = us_to_cyc(PULSE_P90_US, CYC_PER_US);
  localparam int unsigned PULSE_N90_CYC = us_to_cyc(PULSE_N90_US, CYC_PER_US);
  localparam int unsigned CW            = (PERIOD_CYC < 2) ? 1 : $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYC - 1);

  if (CYC_PER_US < 1 || (CLK_FREQ_HZ % 1000000) != 0) begin : g_bad_clk
    $error("CLK_FREQ_HZ must be a nonzero whole multiple of 1 MHz");
  end
  if (PERIOD_CYC < 2 || PULSE_0_CYC < 1 || PULSE_P90_CYC < 1 || PULSE_N90_CYC < 1 ||
      PULSE_0_CYC >= PERIOD_CYC || PULSE_P90_CYC >= PERIOD_CYC ||
      PULSE_N90_CYC >= PERIOD_CYC) begin : g_bad_pulse
    $error("every pulse width must be nonzero and shorter than the frame");
  end

  function automatic logic [CW-1:0] pulse_last(input logic [1:0] pos);
    case (pos)
      POS_P90: return CW'(PULSE_P90_CYC - 1);
      POS_N90: return CW'(PULSE_N90_CYC - 1);
      default: return CW'(PULSE_0_CYC - 1);
    endcase
  endfunction

  servo_state_e  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_pwm, r_err;
  logic [1:0]    r_pos, w_lat_pos;
  logic          w_start, w_last, w_tick, w_restart;

  assign w_last    = (r_cnt == PERIOD_LAST);
  assign w_tick    = (r_state == ST_LOW) && w_last;
  assign w_restart = (r_state == ST_IDLE);
  assign w_lat_pos = (bus.grados == POS_ERR) ? r_pos : bus.grados;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ENABLE is only looked at in IDLE and on the last cycle of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.ENABLE) begin
          w_state_nxt = ST_HIGH;
          w_start     = 1'b1;
        end
      end
      ST_HIGH: if (r_cnt == pulse_last(r_pos)) w_state_nxt = ST_LOW;
      ST_LOW: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (bus.ENABLE) begin
            w_state_nxt = ST_HIGH;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm <= 1'b0;
      r_pos <= POS_0;
      r_err <= 1'b0;
    end else begin
      r_pwm <= (w_state_nxt == ST_HIGH);
      if (w_start) begin
        r_pos <= w_lat_pos;
        r_err <= (bus.grados == POS_ERR);
      end
    end
  end

  servo_settle_cnt #(.SETTLE_FRAMES(SETTLE_FRAMES)) u_settle (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_restart (w_restart),
    .i_new_pos (w_lat_pos),
    .i_cur_pos (r_pos),
    .i_tick    (w_tick),
    .o_settled (bus.settled)
  );

  assign bus.pwm        = r_pwm;
  assign bus.frame_tick = w_tick;
  assign bus.pos_q      = r_pos;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen at a shortened frame (1 MHz, 200 us frame, 15/20/10 us
// pulses): frame table, hand-written corner sequences and a random run vs a frame model.
module tb_servo_pwm_gen;
  localparam int P  = 200;
  localparam int W0 = 15;
  localparam int WP = 20;
  localparam int WN = 10;
  localparam int S  = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  servo_pwm_gen_if bus();

  servo_pwm_gen #(
    .CLK_FREQ_HZ   (1000000),
    .PERIOD_US     (P),
    .PULSE_0_US    (W0),
    .PULSE_P90_US  (WP),
    .PULSE_N90_US  (WN),
    .SETTLE_FRAMES (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame model: where we are inside the current frame, what is latched, and
  // how many whole frames the position has been held.
  bit         m_act;
  int         m_k;
  logic [1:0] m_pos;
  bit         m_err;
  int         m_cnt;

  function automatic int width_of(input logic [1:0] p);
    case (p)
      2'd1:    return WP;
      2'd2:    return WN;
      default: return W0;
    endcase
  endfunction

  task automatic model_clear();
    m_act = 0; m_k = 0; m_pos = 2'd0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_start(input bit from_idle);
    logic [1:0] nw;
    nw = (bus.grados == 2'd3) ? m_pos : bus.grados;
    if (from_idle || nw != m_pos) m_cnt = 0;
    m_err = (bus.grados == 2'd3);
    m_pos = nw;
    m_k   = 0;
    m_act = 1;
  endtask

  task automatic model_step();
    if (reset) model_clear();
    else if (!m_act) begin
      if (bus.ENABLE) model_start(1);
    end else if (m_k == P - 1) begin
      if (m_cnt < S) m_cnt++;
      if (bus.ENABLE) model_start(0);
      else m_act = 0;
    end else m_k++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_chk();
    logic [5:0] exp, act;
    exp = {m_act && (m_k < width_of(m_pos)), m_act && (m_k == P - 1), m_pos, m_cnt >= S, m_err};
    act = {bus.pwm, bus.frame_tick, bus.pos_q, bus.settled, bus.err};
    chk("model {pwm,tick,pos,settled,err}", int'(act), int'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    model_chk();
  endtask

  task automatic run_frame(input int chg_at, input logic en_v, input logic [1:0] g_v,
                           output int hi, output int ticks, output int tick_at);
    hi = 0; ticks = 0; tick_at = -1;
    for (int i = 0; i < P; i++) begin
      if (bus.pwm) hi++;
      if (bus.frame_tick) begin ticks++; tick_at = i; end
      if (i == chg_at) begin bus.ENABLE = en_v; bus.grados = g_v; end
      cyc();
    end
  endtask

  typedef struct {
    logic       en;
    logic [1:0] g;
    int         w;
    int         ticks;
    logic [1:0] pos;
    logic       err;
    logic       st;
  } frame_t;

  frame_t tbl[10];

  initial begin
    int hi, ticks, tick_at;
    // inputs applied mid-pulse (sampled at frame end); expectations for this frame
    tbl[0] = '{1'b1, 2'd0, W0, 1, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'd1, W0, 1, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd1, WP, 1, 2'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd2, WP, 1, 2'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd3, WN, 1, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'd0, WN, 1, 2'd2, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 2'd0, W0, 1, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 2'd0, W0, 1, 2'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 2'd0, W0, 1, 2'd0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 0,  0, 2'd0, 1'b0, 1'b1};

    n_chk = 0; n_err = 0;
    reset = 1'b1; bus.ENABLE = 1'b1; bus.grados = 2'd0;
    model_clear();
    repeat (3) cyc();
    chk("reset outputs", int'({bus.pwm, bus.frame_tick, bus.pos_q, bus.settled, bus.err}), 0);

    reset = 1'b0;
    cyc();
    chk("first pwm after release", int'(bus.pwm), 1);

    for (int f = 0; f < 10; f++) begin
      chk($sformatf("frame%0d pos_q", f), int'(bus.pos_q), int'(tbl[f].pos));
      chk($sformatf("frame%0d err", f), int'(bus.err), int'(tbl[f].err));
      chk($sformatf("frame%0d settled", f), int'(bus.settled), int'(tbl[f].st));
      run_frame(3, tbl[f].en, tbl[f].g, hi, ticks, tick_at);
      chk($sformatf("frame%0d pulse width", f), hi, tbl[f].w);
      chk($sformatf("frame%0d ticks", f), ticks, tbl[f].ticks);
    end
    chk("idle pwm stays low", int'(bus.pwm), 0);

    // Restart from IDLE at the same position still counts as a change.
    bus.ENABLE = 1'b1;
    cyc();
    chk("restart pwm", int'(bus.pwm), 1);
    chk("restart settled", int'(bus.settled), 0);

    // ENABLE 1->0->1 inside one frame: no gap frame; new code 1 takes next frame.
    hi = 0; ticks = 0; tick_at = -1;
    for (int i = 0; i < P; i++) begin
      if (bus.pwm) hi++;
      if (bus.frame_tick) begin ticks++; tick_at = i; end
      if (i == 50) bus.ENABLE = 1'b0;
      if (i == 100) begin bus.ENABLE = 1'b1; bus.grados = 2'd1; end
      cyc();
    end
    chk("toggle frame pulse", hi, W0);
    chk("toggle frame tick position", tick_at, P - 1);
    chk("no gap after toggle", int'(bus.pwm), 1);

    // Async reset in the middle of a pulse, then restart from counter 0.
    repeat (7) cyc();
    chk("pwm high before reset", int'(bus.pwm), 1);
    reset = 1'b1;
    model_clear();
    #1;
    chk("async reset outputs", int'({bus.pwm, bus.frame_tick, bus.pos_q, bus.settled, bus.err}), 0);
    repeat (2) cyc();
    #2;
    reset = 1'b0;
    cyc();
    run_frame(-1, 1'b1, 2'd1, hi, ticks, tick_at);
    chk("post-reset pulse width", hi, WP);
    chk("post-reset tick position", tick_at, P - 1);

    // Random run: the frame model checks every cycle.
    for (int i = 0; i < 40 * P; i++) begin
      if ($urandom_range(49) == 0) bus.grados = 2'($urandom_range(3));
      if ($urandom_range(399) == 0) bus.ENABLE = ~bus.ENABLE;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
